// File: rtl/fwd_hazard_pkg.sv
// Shared encodings for the operand bypass and hazard controller.
package fwd_hazard_pkg;

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_WB  = 2'd1;
  localparam logic [1:0] SEL_MEM = 2'd2;
  localparam logic [1:0] SEL_EXE = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

endpackage

// File: rtl/fwd_mux_ch.sv
// One operand channel: destination compare against EXE/MEM/WB and priority bypass mux.
module fwd_mux_ch
  import fwd_hazard_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_addr,
  input  logic              src_used,
  input  logic [DATA_W-1:0] rf_data,
  input  logic [REG_AW-1:0] exe_dest,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic              exe_wb_en,
  input  logic              mem_wb_en,
  input  logic              wb_wb_en,
  input  logic [DATA_W-1:0] exe_result,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] data,
  output logic [1:0]        sel,
  output logic              hit_exe
);

  logic src_valid;
  logic hit_mem;
  logic hit_wb;

  // r0 reads as zero, so it must never pick up an in-flight write
  assign src_valid = src_used & (src_addr != '0);
  assign hit_exe   = src_valid & exe_wb_en & (src_addr == exe_dest);
  assign hit_mem   = src_valid & mem_wb_en & (src_addr == mem_dest);
  assign hit_wb    = src_valid & wb_wb_en  & (src_addr == wb_dest);

  always_comb begin
    data = rf_data;
    sel  = SEL_RF;
    if (hit_exe) begin
      data = exe_result;
      sel  = SEL_EXE;
    end else if (hit_mem) begin
      data = mem_result;
      sel  = SEL_MEM;
    end else if (hit_wb) begin
      data = wb_result;
      sel  = SEL_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand bypass, load-use stall and data-memory wait/timeout handling with hazard statistics.
module fwd_hazard_unit
  import fwd_hazard_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 3,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [NUM_SRC*DATA_W-1:0] id_src_data,
  input  logic [REG_AW-1:0]         exe_dest,
  input  logic [REG_AW-1:0]         mem_dest,
  input  logic [REG_AW-1:0]         wb_dest,
  input  logic                      exe_wb_en,
  input  logic                      mem_wb_en,
  input  logic                      wb_wb_en,
  input  logic                      exe_mem_r_en,
  input  logic                      mem_mem_en,
  input  logic                      mem_ready,
  input  logic [DATA_W-1:0]         exe_result,
  input  logic [DATA_W-1:0]         mem_result,
  input  logic [DATA_W-1:0]         wb_result,
  output logic [NUM_SRC*DATA_W-1:0] fwd_data,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      stall_id,
  output logic                      flush_exe,
  output logic                      freeze_all,
  output logic                      mem_timeout,
  output logic [CNT_W-1:0]          lu_stall_cnt,
  output logic [CNT_W-1:0]          mem_wait_cnt
);

  localparam int WCW = $clog2(TIMEOUT + 2);
  localparam logic [WCW-1:0] WC_ONE = WCW'(1);
  localparam logic [WCW-1:0] WC_TO  = WCW'(TIMEOUT);
  localparam logic [WCW-1:0] WC_MAX = WCW'(TIMEOUT + 1);

  logic [NUM_SRC-1:0] hit_exe;
  logic               load_use;
  logic               mem_busy;

  state_e             state_q, state_d;
  logic [WCW-1:0]     wait_ctr_q, wait_ctr_d;
  logic               mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]   lu_stall_cnt_q, lu_stall_cnt_d;
  logic [CNT_W-1:0]   mem_wait_cnt_q, mem_wait_cnt_d;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_ch
    fwd_mux_ch #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
    ) u_ch (
      .src_addr   (id_src_addr[i*REG_AW +: REG_AW]),
      .src_used   (id_src_used[i]),
      .rf_data    (id_src_data[i*DATA_W +: DATA_W]),
      .exe_dest   (exe_dest),
      .mem_dest   (mem_dest),
      .wb_dest    (wb_dest),
      .exe_wb_en  (exe_wb_en),
      .mem_wb_en  (mem_wb_en),
      .wb_wb_en   (wb_wb_en),
      .exe_result (exe_result),
      .mem_result (mem_result),
      .wb_result  (wb_result),
      .data       (fwd_data[i*DATA_W +: DATA_W]),
      .sel        (fwd_sel[i*2 +: 2]),
      .hit_exe    (hit_exe[i])
    );
  end

  assign load_use = (|hit_exe) & exe_mem_r_en;
  assign mem_busy = mem_mem_en & ~mem_ready;

  // Freeze wins over load-use; the bubble is deferred to the first unfrozen cycle
  assign freeze_all = rst & mem_busy;
  assign stall_id   = rst & (mem_busy | load_use);
  assign flush_exe  = rst & ~mem_busy & load_use;

  always_comb begin
    state_d       = state_q;
    wait_ctr_d    = wait_ctr_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      ST_RUN: begin
        if (mem_busy) begin
          wait_ctr_d = WC_ONE;
          if (WC_ONE >= WC_TO) begin
            mem_timeout_d = 1'b1;
            state_d       = ST_ERR;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mem_ready || !mem_mem_en) begin
          state_d    = ST_RUN;
          wait_ctr_d = '0;
        end else begin
          if (wait_ctr_q != WC_MAX) wait_ctr_d = wait_ctr_q + WC_ONE;
          if (wait_ctr_d >= WC_TO) begin
            mem_timeout_d = 1'b1;
            state_d       = ST_ERR;
          end
        end
      end
      ST_ERR: begin
        if (mem_ready) begin
          state_d    = ST_RUN;
          wait_ctr_d = '0;
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_ctr_d = '0;
      end
    endcase
  end

  always_comb begin
    lu_stall_cnt_d = lu_stall_cnt_q;
    mem_wait_cnt_d = mem_wait_cnt_q;
    if (load_use && !mem_busy && (lu_stall_cnt_q != '1))
      lu_stall_cnt_d = lu_stall_cnt_q + CNT_W'(1);
    if (mem_busy && (mem_wait_cnt_q != '1))
      mem_wait_cnt_d = mem_wait_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_RUN;
      wait_ctr_q     <= '0;
      mem_timeout_q  <= 1'b0;
      lu_stall_cnt_q <= '0;
      mem_wait_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_ctr_q     <= wait_ctr_d;
      mem_timeout_q  <= mem_timeout_d;
      lu_stall_cnt_q <= lu_stall_cnt_d;
      mem_wait_cnt_q <= mem_wait_cnt_d;
    end
  end

  assign mem_timeout  = mem_timeout_q;
  assign lu_stall_cnt = lu_stall_cnt_q;
  assign mem_wait_cnt = mem_wait_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: bypass priority, load-use, memory wait, timeout and reset.
module tb_fwd_hazard_unit;
  import fwd_hazard_pkg::*;

  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int NUM_SRC = 3;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;

  logic                      clk;
  logic                      rst;
  logic [NUM_SRC*REG_AW-1:0] id_src_addr;
  logic [NUM_SRC-1:0]        id_src_used;
  logic [NUM_SRC*DATA_W-1:0] id_src_data;
  logic [REG_AW-1:0]         exe_dest, mem_dest, wb_dest;
  logic                      exe_wb_en, mem_wb_en, wb_wb_en;
  logic                      exe_mem_r_en, mem_mem_en, mem_ready;
  logic [DATA_W-1:0]         exe_result, mem_result, wb_result;
  logic [NUM_SRC*DATA_W-1:0] fwd_data;
  logic [NUM_SRC*2-1:0]      fwd_sel;
  logic                      stall_id, flush_exe, freeze_all, mem_timeout;
  logic [CNT_W-1:0]          lu_stall_cnt, mem_wait_cnt;

  int checks = 0;
  int errors = 0;

  fwd_hazard_unit #(
    .DATA_W  (DATA_W),
    .REG_AW  (REG_AW),
    .NUM_SRC (NUM_SRC),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_src_addr  (id_src_addr),
    .id_src_used  (id_src_used),
    .id_src_data  (id_src_data),
    .exe_dest     (exe_dest),
    .mem_dest     (mem_dest),
    .wb_dest      (wb_dest),
    .exe_wb_en    (exe_wb_en),
    .mem_wb_en    (mem_wb_en),
    .wb_wb_en     (wb_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .mem_mem_en   (mem_mem_en),
    .mem_ready    (mem_ready),
    .exe_result   (exe_result),
    .mem_result   (mem_result),
    .wb_result    (wb_result),
    .fwd_data     (fwd_data),
    .fwd_sel      (fwd_sel),
    .stall_id     (stall_id),
    .flush_exe    (flush_exe),
    .freeze_all   (freeze_all),
    .mem_timeout  (mem_timeout),
    .lu_stall_cnt (lu_stall_cnt),
    .mem_wait_cnt (mem_wait_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    id_src_addr  = '0;
    id_src_used  = '0;
    id_src_data  = '0;
    exe_dest     = '0;
    mem_dest     = '0;
    wb_dest      = '0;
    exe_wb_en    = 1'b0;
    mem_wb_en    = 1'b0;
    wb_wb_en     = 1'b0;
    exe_mem_r_en = 1'b0;
    mem_mem_en   = 1'b0;
    mem_ready    = 1'b0;
    exe_result   = '0;
    mem_result   = '0;
    wb_result    = '0;
  endtask

  task automatic set_src(input int ch, input logic [REG_AW-1:0] a, input logic used,
                         input logic [DATA_W-1:0] d);
    id_src_addr[ch*REG_AW +: REG_AW] = a;
    id_src_used[ch]                  = used;
    id_src_data[ch*DATA_W +: DATA_W] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use();
    exe_mem_r_en = 1'b1;
    exe_dest     = 5'd9;
    exe_wb_en    = 1'b1;
    exe_result   = 32'h0;
    set_src(1, 5'd9, 1'b1, 32'h0000_0111);
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    mem_mem_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_freeze_gated", freeze_all, 1'b0);
    chk("rst_stall_gated", stall_id, 1'b0);
    chk("rst_timeout", mem_timeout, 1'b0);
    chk("rst_lu_cnt", lu_stall_cnt, 4'd0);
    chk("rst_mw_cnt", mem_wait_cnt, 4'd0);
    clear_inputs();
    rst = 1'b1;
    step();

    // forwarding priority EXE > MEM > WB > regfile
    set_src(0, 5'd5, 1'b1, 32'h1111_0000);
    exe_dest = 5'd5; mem_dest = 5'd5; wb_dest = 5'd5;
    exe_wb_en = 1'b1; mem_wb_en = 1'b1; wb_wb_en = 1'b1;
    exe_result = 32'hAAAA_0001; mem_result = 32'hBBBB_0002; wb_result = 32'hCCCC_0003;
    #1;
    chk("prio_exe_data", fwd_data[31:0], 32'hAAAA_0001);
    chk("prio_exe_sel", fwd_sel[1:0], 2'd3);
    chk("prio_no_stall", stall_id, 1'b0);
    exe_wb_en = 1'b0;
    #1;
    chk("prio_mem_data", fwd_data[31:0], 32'hBBBB_0002);
    chk("prio_mem_sel", fwd_sel[1:0], 2'd2);
    mem_wb_en = 1'b0;
    #1;
    chk("prio_wb_data", fwd_data[31:0], 32'hCCCC_0003);
    chk("prio_wb_sel", fwd_sel[1:0], 2'd1);
    wb_wb_en = 1'b0;
    #1;
    chk("prio_rf_data", fwd_data[31:0], 32'h1111_0000);
    chk("prio_rf_sel", fwd_sel[1:0], 2'd0);

    // r0 never forwarded, unused channel never forwarded, other channel still hits
    clear_inputs();
    set_src(0, 5'd0, 1'b1, 32'h1234_5678);
    set_src(1, 5'd7, 1'b0, 32'h0000_0077);
    set_src(2, 5'd7, 1'b1, 32'h0000_0099);
    exe_dest = 5'd0; exe_wb_en = 1'b1; exe_result = 32'hEEEE_EEEE;
    mem_dest = 5'd7; mem_wb_en = 1'b1; mem_result = 32'h7777_0007;
    #1;
    chk("r0_sel", fwd_sel[1:0], 2'd0);
    chk("r0_data", fwd_data[31:0], 32'h1234_5678);
    chk("unused_sel", fwd_sel[3:2], 2'd0);
    chk("unused_data", fwd_data[63:32], 32'h0000_0077);
    chk("ch2_mem_sel", fwd_sel[5:4], 2'd2);
    chk("ch2_mem_data", fwd_data[95:64], 32'h7777_0007);

    // load-use
    step();
    clear_inputs();
    set_load_use();
    #1;
    chk("lu_stall", stall_id, 1'b1);
    chk("lu_flush", flush_exe, 1'b1);
    chk("lu_freeze", freeze_all, 1'b0);
    chk("lu_sel_exe", fwd_sel[3:2], 2'd3);
    chk("lu_cnt_before", lu_stall_cnt, 4'd0);
    step();
    chk("lu_cnt_after", lu_stall_cnt, 4'd1);
    clear_inputs();
    set_src(1, 5'd9, 1'b1, 32'h0000_0111);
    mem_dest = 5'd9; mem_wb_en = 1'b1; mem_mem_en = 1'b1; mem_ready = 1'b1;
    mem_result = 32'hDEAD_0009;
    #1;
    chk("lu_mem_sel", fwd_sel[3:2], 2'd2);
    chk("lu_mem_data", fwd_data[63:32], 32'hDEAD_0009);
    chk("lu_resolved", stall_id, 1'b0);
    step();
    chk("lu_cnt_hold", lu_stall_cnt, 4'd1);

    // memory wait with a pending load-use
    clear_inputs();
    set_load_use();
    mem_mem_en = 1'b1; mem_ready = 1'b0;
    #1;
    chk("mw_freeze", freeze_all, 1'b1);
    chk("mw_flush", flush_exe, 1'b0);
    chk("mw_stall", stall_id, 1'b1);
    repeat (4) step();
    chk("mw_cnt4", mem_wait_cnt, 4'd4);
    chk("mw_lu_hold", lu_stall_cnt, 4'd1);
    chk("mw_state_wait", dut.state_q, ST_WAIT);
    mem_ready = 1'b1;
    #1;
    chk("mw_unfrozen", freeze_all, 1'b0);
    chk("mw_flush_now", flush_exe, 1'b1);
    step();
    chk("mw_state_run", dut.state_q, ST_RUN);
    chk("mw_lu_cnt2", lu_stall_cnt, 4'd2);
    chk("mw_cnt_hold", mem_wait_cnt, 4'd4);
    mem_mem_en = 1'b0;
    #1;
    chk("mw_flush_next", flush_exe, 1'b1);
    step();
    chk("mw_lu_cnt3", lu_stall_cnt, 4'd3);

    // timeout after 8 busy cycles
    clear_inputs();
    mem_mem_en = 1'b1; mem_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 7) begin
        chk("to_not_yet", mem_timeout, 1'b0);
        chk("to_state_wait", dut.state_q, ST_WAIT);
      end
      if (k == 8) begin
        chk("to_set", mem_timeout, 1'b1);
        chk("to_state_err", dut.state_q, ST_ERR);
      end
    end
    chk("to_mw_cnt14", mem_wait_cnt, 4'd14);
    chk("to_err_freeze", freeze_all, 1'b1);
    repeat (3) step();
    chk("mw_cnt_sat", mem_wait_cnt, 4'hF);
    mem_ready = 1'b1;
    #1;
    chk("to_err_release", freeze_all, 1'b0);
    step();
    chk("to_state_run", dut.state_q, ST_RUN);
    chk("to_sticky", mem_timeout, 1'b1);

    // asynchronous reset in the middle of WAIT
    clear_inputs();
    set_load_use();
    mem_mem_en = 1'b1; mem_ready = 1'b0;
    step();
    chk("rw_state_wait", dut.state_q, ST_WAIT);
    #2;
    rst = 1'b0;
    #1;
    chk("rw_timeout_clr", mem_timeout, 1'b0);
    chk("rw_lu_clr", lu_stall_cnt, 4'd0);
    chk("rw_mw_clr", mem_wait_cnt, 4'd0);
    chk("rw_stall_gated", stall_id, 1'b0);
    chk("rw_flush_gated", flush_exe, 1'b0);
    chk("rw_freeze_gated", freeze_all, 1'b0);
    chk("rw_state_run", dut.state_q, ST_RUN);
    step();
    clear_inputs();
    mem_mem_en = 1'b1; mem_ready = 1'b1;
    rst = 1'b1;
    step();
    chk("rw_post_state", dut.state_q, ST_RUN);
    chk("rw_post_mw", mem_wait_cnt, 4'd0);
    chk("rw_post_to", mem_timeout, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parametrised successor to the single-issue forwarding logic: per-source operand bypass from the EXE, MEM and WB stages, plus load-use stall and data-memory wait-state handling. It sits beside the ID/EXE pipeline register, feeding bypassed operands into EXE and driving the PC/IF-ID hold and the ID-EXE bubble. It also keeps saturating hazard statistics and a sticky memory-timeout flag.

Parameters:
DATA_W, 32, operand/result width
REG_AW, 5, register address width; address 0 is hard-wired zero and is never forwarded
NUM_SRC, 3, operand channels (rs1, rs2, store data)
TIMEOUT, 255, max consecutive mem_ready=0 cycles before mem_timeout is set
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
id_src_addr  in  NUM_SRC*REG_AW  source register addresses in ID; channel i at [i*REG_AW +: REG_AW]
id_src_used  in  NUM_SRC  channel i actually reads a register (0 for immediate or unused)
id_src_data  in  NUM_SRC*DATA_W  register-file read data
exe_dest, mem_dest, wb_dest  in  REG_AW each  destination register per stage
exe_wb_en, mem_wb_en, wb_wb_en  in  1 each  stage will write back
exe_mem_r_en  in  1  instruction in EXE is a load
mem_mem_en  in  1  MEM stage is performing a load or store
mem_ready  in  1  data-memory handshake; 1 = access completes this cycle
exe_result, mem_result, wb_result  in  DATA_W each  value each stage will write back (mem_result is load data when the MEM stage holds a load)
fwd_data  out  NUM_SRC*DATA_W  bypassed operands
fwd_sel  out  NUM_SRC*2  per channel: 0 = regfile, 1 = WB, 2 = MEM, 3 = EXE
stall_id  out  1  hold PC and IF/ID
flush_exe  out  1  insert bubble into ID/EXE
freeze_all  out  1  hold every pipeline register
mem_timeout  out  1  sticky error
lu_stall_cnt  out  CNT_W  load-use stall cycles, saturating
mem_wait_cnt  out  CNT_W  memory wait cycles, saturating

Behaviour:
- Match per channel i: hit_S = id_src_used[i] & S_wb_en & (src == S_dest) & (src != 0), for S in {EXE, MEM, WB}.
- Priority EXE > MEM > WB > regfile. fwd_data and fwd_sel are fully combinational, with zero latency.
- A hit_EXE with exe_mem_r_en=1 is a load-use hazard. fwd_sel still reports 3, but the value is discarded by the stall.
- load_use = OR over channels of (hit_EXE & exe_mem_r_en).
- mem_busy = mem_mem_en & ~mem_ready.
- Priority of control outputs:
  - mem_busy: freeze_all=1, stall_id=1, flush_exe=0.
  - else load_use: stall_id=1, flush_exe=1, freeze_all=0.
  - else all 0.
  - Freeze always dominates load-use. No bubble is inserted while frozen; the load-use is resolved on the first unfrozen cycle.
- FSM (registered, 2 bits):
  - RUN: if mem_busy, go to WAIT and load wait_ctr=1.
  - WAIT: if mem_ready or ~mem_mem_en, go to RUN and clear wait_ctr. Otherwise wait_ctr++ (saturating at TIMEOUT+1). When wait_ctr reaches TIMEOUT, set mem_timeout and go to ERR.
  - ERR: freeze continues while mem_busy. When mem_ready=1, go to RUN. mem_timeout stays 1 until reset.
  - Unused encoding: go to RUN.
- Counters:
  - lu_stall_cnt increments on each cycle with load_use & ~mem_busy.
  - mem_wait_cnt increments on each cycle with mem_busy.
  - Both saturate at all-ones and never wrap.
- Reset (rst=0, any time, including mid-WAIT):
  - Immediately: state=RUN, wait_ctr=0, mem_timeout=0, both counters=0.
  - stall_id, flush_exe and freeze_all are gated to 0 while rst=0.
  - fwd_data/fwd_sel stay combinational.
- All registers update only on the rising clk edge while rst=1.

Decomposition:
- Package fwd_hazard_pkg holds:
  - fwd_sel encodings SEL_RF/SEL_WB/SEL_MEM/SEL_EXE;
  - FSM state constants ST_RUN/ST_WAIT/ST_ERR.
- Sub-module fwd_mux_ch: one operand channel (compare plus priority mux), instantiated NUM_SRC times by generate. It outputs hit_EXE for load-use reduction.

Test Plan:
- Forward priority: ch0 src=5, exe_dest=mem_dest=wb_dest=5, all wb_en=1, exe_result=0xAAAA0001, mem_result=0xBBBB0002 -> fwd_data ch0=0xAAAA0001, fwd_sel=3. Drop exe_wb_en -> 0xBBBB0002, sel=2. Drop mem_wb_en -> wb_result, sel=1.
- Register zero and unused: src=0 matching exe_dest=0 with wb_en=1 -> sel=0, regfile data passes. src=7 hit but id_src_used=0 -> sel=0.
- Load-use: exe_mem_r_en=1, exe_dest=9, ch1 src=9 used -> stall_id=1, flush_exe=1, freeze_all=0, lu_stall_cnt 0->1 next edge. Next cycle the load is in MEM with mem_ready=1 -> sel=2, no stall.
- Memory wait: mem_mem_en=1, mem_ready=0 for 4 cycles alongside a load-use -> freeze_all=1, flush_exe=0, mem_wait_cnt=4, lu_stall_cnt unchanged. mem_ready=1 -> state RUN; flush_exe=1 the following cycle.
- Timeout: TIMEOUT=8, mem_ready=0 for 10 cycles -> mem_timeout=1 at cycle 8, state ERR. mem_ready=1 -> RUN, mem_timeout stays 1.
- Reset mid-WAIT: assert rst=0 asynchronously in WAIT with counters nonzero -> immediately mem_timeout=0, counters=0, all stall outputs 0. After release with mem_ready=1 -> RUN.
